// File: rtl/data_mem_resp_if.sv
// Shared load/store type and the request/response bus between the core and data_mem_resp.
// The package sits here so the interface and the memory block see one definition.
package riscv_pkg;
  typedef enum logic {
    Read  = 1'b0,
    Write = 1'b1
  } DataMem_sel_e;
endpackage

interface data_mem_resp_if;
  import riscv_pkg::*;

  logic         req_valid;
  DataMem_sel_e req_rw;
  logic [31:0]  req_addr;
  logic [31:0]  req_wdata;
  logic         req_ready;
  logic         resp_valid;
  logic [31:0]  resp_rdata;
  logic         resp_err;

  modport master (
    output req_valid, req_rw, req_addr, req_wdata,
    input  req_ready, resp_valid, resp_rdata, resp_err
  );

  modport slave (
    input  req_valid, req_rw, req_addr, req_wdata,
    output req_ready, resp_valid, resp_rdata, resp_err
  );
endinterface

// File: rtl/data_mem_resp.sv
// Word-addressed data memory with a fixed-latency, one-outstanding-request response path.
// A request is captured in IDLE, waits LATENCY cycles, and completes in a single RESP cycle.
module data_mem_resp #(
  parameter int unsigned DEPTH   = 256,
  parameter int unsigned LATENCY = 2
) (
  input  logic            clk,
  input  logic            rst,
  data_mem_resp_if.slave  bus
);
  import riscv_pkg::*;

  localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    RESP
  } state_e;

  state_e          state_q, state_d;
  logic [3:0]      cnt_q, cnt_d;
  DataMem_sel_e    rw_q, rw_d;
  logic [31:0]     addr_q, addr_d;
  logic [31:0]     wdata_q, wdata_d;

  logic [31:0]     mem [DEPTH];
  logic [IDX_W-1:0] idx;
  logic            addr_err;
  logic            in_resp;
  logic            mem_we;

  assign idx      = addr_q[IDX_W+1:2];
  assign addr_err = (addr_q[1:0] != 2'b00) || ({2'b00, addr_q[31:2]} >= 32'(DEPTH));
  assign in_resp  = (state_q == RESP) && !rst;
  assign mem_we   = in_resp && (rw_q == Write) && !addr_err;

  // NOTE: every variable driven here gets a default first so no path infers a latch.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rw_d    = rw_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;

    unique case (state_q)
      IDLE: begin
        if (bus.req_valid) begin
          rw_d    = bus.req_rw;
          addr_d  = bus.req_addr;
          wdata_d = bus.req_wdata;
          if (LATENCY == 1) begin
            state_d = RESP;
          end else begin
            state_d = BUSY;
            cnt_d   = 4'(int'(LATENCY) - 2);
          end
        end
      end
      BUSY: begin
        if (cnt_q == 4'd0) state_d = RESP;
        else               cnt_d   = cnt_q - 4'd1;
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs are masked by rst so an aborted access never shows a response.
  always_comb begin
    bus.req_ready  = (state_q == IDLE) || rst;
    bus.resp_valid = in_resp;
    bus.resp_err   = in_resp && addr_err;
    bus.resp_rdata = 32'd0;
    if (in_resp && !addr_err && (rw_q == Read)) bus.resp_rdata = mem[idx];
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      rw_q    <= Read;
      addr_q  <= 32'd0;
      wdata_q <= 32'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rw_q    <= rw_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
    end
  end

  // NOTE: the array has no reset; clearing it would turn the RAM into a flop bank.
  always_ff @(posedge clk) begin
    if (mem_we) mem[idx] <= wdata_q;
  end
endmodule

// File: tb/tb_data_mem_resp.sv
// Directed and randomized checks of data_mem_resp against a word-level reference memory.
// A second instance built with LATENCY=1 covers the minimum-latency timing.
module tb_data_mem_resp;
  import riscv_pkg::*;

  localparam int unsigned DEPTH  = 256;
  localparam int unsigned LAT    = 2;
  localparam int          PERIOD = 10;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;
  time  last_acc = 0;
  logic [31:0] mdl [int unsigned];

  data_mem_resp_if a ();
  data_mem_resp_if b ();

  data_mem_resp #(.DEPTH(DEPTH), .LATENCY(LAT)) dut_a (.clk(clk), .rst(rst), .bus(a.slave));
  data_mem_resp #(.DEPTH(DEPTH), .LATENCY(1))   dut_b (.clk(clk), .rst(rst), .bus(b.slave));

  always #(PERIOD/2) clk = ~clk;

  initial begin
    #(PERIOD * 20000);
    $display("FAIL watchdog: simulation did not finish, observed timeout required completion");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One full transaction on the LATENCY=2 instance, checked cycle by cycle.
  task automatic req_a(input DataMem_sel_e rw, input logic [31:0] addr, input logic [31:0] wdata,
                       input bit keep, input bit scramble, input bit chk_spacing);
    bit          err;
    bit          rd_known;
    logic [31:0] exp_rd;
    int unsigned idx;
    idx      = int'(addr[31:2]);
    err      = (addr[1:0] != 2'b00) || (idx >= DEPTH);
    rd_known = 1'b1;
    exp_rd   = 32'd0;
    if (!err && rw == Read) begin
      if (mdl.exists(idx)) exp_rd = mdl[idx];
      else                 rd_known = 1'b0;
    end
    @(negedge clk);
    a.req_valid = 1'b1;
    a.req_rw    = rw;
    a.req_addr  = addr;
    a.req_wdata = wdata;
    check("ready_idle", 32'(a.req_ready), 32'd1);
    check("no_stray_resp", 32'(a.resp_valid), 32'd0);
    @(posedge clk);
    if (chk_spacing) check("accept_spacing", 32'((($time - last_acc) / PERIOD)), 32'(LAT + 1));
    last_acc = $time;
    for (int k = 1; k <= int'(LAT); k++) begin
      @(negedge clk);
      if (k == 1) begin
        if (!keep) a.req_valid = 1'b0;
        if (scramble) begin
          a.req_addr  = $urandom;
          a.req_wdata = $urandom;
          a.req_rw    = (rw == Read) ? Write : Read;
        end
      end
      check("resp_valid_timing", 32'(a.resp_valid), 32'(k == int'(LAT)));
      check("ready_low_busy", 32'(a.req_ready), 32'd0);
      if (k == int'(LAT)) begin
        check("resp_err", 32'(a.resp_err), 32'(err));
        if (rd_known) check("resp_rdata", a.resp_rdata, exp_rd);
      end else begin
        check("rdata_zero_busy", a.resp_rdata, 32'd0);
      end
    end
    if (rw == Write && !err) mdl[idx] = wdata;
  endtask

  task automatic drop_a();
    @(negedge clk);
    a.req_valid = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    a.req_valid = 1'b1; a.req_rw = Write; a.req_addr = 32'h0; a.req_wdata = 32'hFFFF_FFFF;
    b.req_valid = 1'b0; b.req_rw = Read;  b.req_addr = 32'h0; b.req_wdata = 32'h0;

    // Reset state, with a request held on the bus that must not be taken.
    repeat (3) begin
      @(negedge clk);
      check("rst_ready", 32'(a.req_ready), 32'd1);
      check("rst_resp_valid", 32'(a.resp_valid), 32'd0);
      check("rst_rdata", a.resp_rdata, 32'd0);
      check("rst_err", 32'(a.resp_err), 32'd0);
    end
    rst = 1'b0;
    a.req_valid = 1'b0;
    repeat (3) begin
      @(negedge clk);
      check("post_rst_ready", 32'(a.req_ready), 32'd1);
      check("post_rst_no_resp", 32'(a.resp_valid), 32'd0);
    end

    // Basic write then read-back.
    req_a(Write, 32'h10, 32'hDEAD_BEEF, 1'b0, 1'b0, 1'b0);
    req_a(Read,  32'h10, 32'h0,         1'b0, 1'b0, 1'b0);

    // Error cases: misaligned read, out-of-range write leaves memory alone.
    req_a(Write, 32'h0,   32'h0BAD_F00D, 1'b0, 1'b0, 1'b0);
    req_a(Read,  32'h12,  32'h0,         1'b0, 1'b0, 1'b0);
    req_a(Write, 32'(4 * DEPTH), 32'h1,  1'b0, 1'b0, 1'b0);
    req_a(Read,  32'h0,   32'h0,         1'b0, 1'b0, 1'b0);

    // Reset landing in the RESP cycle of a write aborts it.
    req_a(Write, 32'h30, 32'hAA, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    a.req_valid = 1'b1; a.req_rw = Write; a.req_addr = 32'h30; a.req_wdata = 32'h55;
    @(posedge clk); #1 a.req_valid = 1'b0;
    @(posedge clk); #1 rst = 1'b1;
    @(negedge clk);
    check("abort_resp_no_pulse", 32'(a.resp_valid), 32'd0);
    check("abort_resp_ready", 32'(a.req_ready), 32'd1);
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    check("abort_resp_idle", 32'(a.req_ready), 32'd1);
    check("abort_resp_quiet", 32'(a.resp_valid), 32'd0);
    req_a(Read, 32'h30, 32'h0, 1'b0, 1'b0, 1'b0);

    // Reset landing in BUSY also aborts.
    req_a(Write, 32'h34, 32'h11, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    a.req_valid = 1'b1; a.req_rw = Write; a.req_addr = 32'h34; a.req_wdata = 32'h66;
    @(posedge clk); #1 begin a.req_valid = 1'b0; rst = 1'b1; end
    @(negedge clk);
    check("abort_busy_no_pulse", 32'(a.resp_valid), 32'd0);
    @(posedge clk); #1 rst = 1'b0;
    repeat (2) begin
      @(negedge clk);
      check("abort_busy_quiet", 32'(a.resp_valid), 32'd0);
      check("abort_busy_ready", 32'(a.req_ready), 32'd1);
    end
    req_a(Read, 32'h34, 32'h0, 1'b0, 1'b0, 1'b0);

    // Continuous req_valid, alternating write/read to one word: one accept per LAT+1 cycles.
    req_a(Write, 32'h20, $urandom, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 6; i++) begin
      if (i % 2 == 0) req_a(Read,  32'h20, 32'h0,    1'b1, 1'b0, 1'b1);
      else            req_a(Write, 32'h20, $urandom, 1'b1, 1'b0, 1'b1);
    end
    drop_a();

    // Inputs changing after acceptance must not leak into the access.
    req_a(Write, 32'h40, 32'h1234_5678, 1'b0, 1'b1, 1'b0);
    req_a(Read,  32'h40, 32'h0,         1'b0, 1'b1, 1'b0);

    // Randomized traffic against the reference memory.
    for (int i = 0; i < 60; i++) begin
      logic [31:0] addr;
      DataMem_sel_e rw;
      addr = 32'($urandom_range(0, 15)) * 4;
      if ($urandom_range(0, 5) == 0) addr = 32'($urandom_range(DEPTH - 2, DEPTH + 3)) * 4;
      if ($urandom_range(0, 7) == 0) addr = addr + 32'($urandom_range(1, 3));
      if ($urandom_range(0, 19) == 0) addr = $urandom | 32'h8000_0000;
      rw = ($urandom_range(0, 1) == 1) ? Write : Read;
      req_a(rw, addr, $urandom, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b0);
    end
    drop_a();

    // Minimum latency instance: response one cycle after acceptance, next accept two edges later.
    @(negedge clk);
    b.req_valid = 1'b1; b.req_rw = Write; b.req_addr = 32'h8; b.req_wdata = 32'hCAFE_0001;
    check("l1_ready_idle", 32'(b.req_ready), 32'd1);
    @(posedge clk);
    @(negedge clk);
    check("l1_write_resp", 32'(b.resp_valid), 32'd1);
    check("l1_write_err", 32'(b.resp_err), 32'd0);
    check("l1_write_rdata", b.resp_rdata, 32'd0);
    check("l1_ready_resp", 32'(b.req_ready), 32'd0);
    b.req_rw = Read;
    @(negedge clk);
    check("l1_ready_back", 32'(b.req_ready), 32'd1);
    check("l1_no_resp_idle", 32'(b.resp_valid), 32'd0);
    @(negedge clk);
    b.req_valid = 1'b0;
    check("l1_read_resp", 32'(b.resp_valid), 32'd1);
    check("l1_read_rdata", b.resp_rdata, 32'hCAFE_0001);
    @(negedge clk);
    check("l1_single_pulse", 32'(b.resp_valid), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
